// File: rtl/axonerve_kvs_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// axonerve_kvs_axi_mem_responder : AXI4 slave with on-chip word RAM, INCR bursts
// Revision : 1.0
// ============================================================================
module axonerve_kvs_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                              ap_clk,
  input  logic                              areset,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  output logic                              proto_err
);

  localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IW    = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 addr_q, addr_d;
  logic [7:0]                    len_q, len_d;
  logic [8:0]                    cnt_q, cnt_d;
  logic                          last_wr_q, last_wr_d;
  logic                          perr_q, perr_d;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];
  logic [C_S_AXI_DATA_WIDTH-1:0] ram_rd_q;
  logic                          infl_q, infl_last_q;

  logic [1:0]                    fill_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] e0_data_q, e1_data_q;
  logic                          e0_last_q, e1_last_q;

  logic                          aw_rdy, ar_rdy, w_rdy;
  logic                          ram_we, ram_re;
  logic                          beat_last, rvalid, pop;
  logic [2:0]                    occ;

  logic                          unused;
  assign unused = &{1'b0, s_axi_awaddr, s_axi_araddr};

  assign beat_last = (cnt_q == {1'b0, len_q});
  assign rvalid    = (fill_q != 2'd0);
  assign pop       = rvalid & s_axi_rready;
  // Entries in the skid buffer plus the read in flight; never exceeds 2.
  assign occ       = {1'b0, fill_q} + {2'b00, infl_q};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    perr_d    = perr_q;
    aw_rdy    = 1'b0;
    ar_rdy    = 1'b0;
    w_rdy     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axi_awvalid && (!s_axi_arvalid || !last_wr_q)) begin
          aw_rdy    = 1'b1;
          addr_d    = s_axi_awaddr[OFF +: IW];
          len_d     = s_axi_awlen;
          cnt_d     = 9'd0;
          last_wr_d = 1'b1;
          state_d   = WR_DATA;
        end else if (s_axi_arvalid) begin
          ar_rdy    = 1'b1;
          addr_d    = s_axi_araddr[OFF +: IW];
          len_d     = s_axi_arlen;
          cnt_d     = 9'd0;
          last_wr_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      WR_DATA: begin
        w_rdy = 1'b1;
        if (s_axi_wvalid) begin
          ram_we = 1'b1;
          if (s_axi_wlast != beat_last) perr_d = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 9'd1;
          if (beat_last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi_bready) state_d = IDLE;
      end
      RD_DATA: begin
        // Issue a RAM read only when its data is guaranteed a skid slot.
        if ((cnt_q <= {1'b0, len_q}) && ((occ < 3'd2) || ((occ == 3'd2) && pop))) begin
          ram_re = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 9'd1;
        end
        if (pop && e0_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= 8'd0;
      cnt_q     <= 9'd0;
      last_wr_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      perr_q    <= perr_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ram_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[addr_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (ram_re) ram_rd_q <= mem[addr_q];
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= ram_re;
      infl_last_q <= ram_re & beat_last;
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      fill_q    <= 2'd0;
      e0_data_q <= '0;
      e1_data_q <= '0;
      e0_last_q <= 1'b0;
      e1_last_q <= 1'b0;
    end else begin
      case (fill_q)
        2'd0: begin
          if (infl_q) begin
            e0_data_q <= ram_rd_q;
            e0_last_q <= infl_last_q;
            fill_q    <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && infl_q) begin
            e0_data_q <= ram_rd_q;
            e0_last_q <= infl_last_q;
          end else if (pop) begin
            fill_q    <= 2'd0;
          end else if (infl_q) begin
            e1_data_q <= ram_rd_q;
            e1_last_q <= infl_last_q;
            fill_q    <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            e0_data_q <= e1_data_q;
            e0_last_q <= e1_last_q;
            if (infl_q) begin
              e1_data_q <= ram_rd_q;
              e1_last_q <= infl_last_q;
            end else begin
              fill_q    <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign s_axi_awready = aw_rdy;
  assign s_axi_arready = ar_rdy;
  assign s_axi_wready  = w_rdy;
  assign s_axi_bvalid  = (state_q == WR_RESP);
  assign s_axi_rvalid  = rvalid;
  assign s_axi_rdata   = e0_data_q;
  assign s_axi_rlast   = rvalid & e0_last_q;
  assign proto_err     = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_axonerve_kvs_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_axonerve_kvs_axi_mem_responder : directed bench for the AXI memory responder
// Revision : 1.0
// ============================================================================
module tb_axonerve_kvs_axi_mem_responder;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int D  = 16;

  logic          ap_clk = 1'b0;
  logic          areset;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast, perr;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] wbuf [16];
  logic [7:0]  sbuf [16];
  logic [63:0] ebuf [16];

  always #5 ap_clk = ~ap_clk;

  axonerve_kvs_axi_mem_responder #(
    .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_MEM_DEPTH(D)
  ) dut (
    .ap_clk(ap_clk), .areset(areset),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .proto_err(perr)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input logic [63:0] addr, input int len, input int wlast_at);
    int t;
    @(negedge ap_clk);
    awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
    t = 0; #1;
    while (!awready && t < 50) begin @(negedge ap_clk); #1; t++; end
    chk_eq("aw_grant", awready, 1'b1);
    @(negedge ap_clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == wlast_at);
      #1;
      chk_eq("wready", wready, 1'b1);
      chk_eq("b_early", bvalid, 1'b0);
      @(negedge ap_clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1 chk_eq("b_resp", bvalid, 1'b1);
    @(negedge ap_clk);
    #1 chk_eq("b_done", bvalid, 1'b0);
  endtask

  // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating
  task automatic rd_burst(input logic [63:0] addr, input int len, input int mode);
    int t, k;
    logic        held;
    logic [63:0] held_data;
    @(negedge ap_clk);
    araddr = addr; arlen = len[7:0]; arvalid = 1'b1; rready = 1'b0;
    t = 0; #1;
    while (!arready && t < 50) begin @(negedge ap_clk); #1; t++; end
    chk_eq("ar_grant", arready, 1'b1);
    @(negedge ap_clk);
    arvalid = 1'b0;
    #1 chk_eq("r_lat0", rvalid, 1'b0);
    @(negedge ap_clk);
    #1 chk_eq("r_lat1", rvalid, 1'b0);
    @(negedge ap_clk);
    #1;
    k = 0; t = 0; held = 1'b0; held_data = '0;
    while (k <= len && t < 100) begin
      rready = (mode == 0) ? 1'b1 : ((t % 3) == 0);
      #1;
      if (t == 0) chk_eq("r_first", rvalid, 1'b1);
      if (rvalid && held) chk_eq("r_stable", rdata, held_data);
      if (rvalid && rready) begin
        chk_eq("r_data", rdata, ebuf[k]);
        chk_eq("r_last", rlast, (k == len));
        k++;
        held = 1'b0;
      end else if (rvalid) begin
        held = 1'b1;
        held_data = rdata;
      end
      @(negedge ap_clk); #1;
      t++;
    end
    chk_eq("r_count", k, len + 1);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] order;
    int g, t;
    areset = 1'b1;
    awvalid = 0; awaddr = '0; awlen = '0; wvalid = 0; wdata = '0; wstrb = '0; wlast = 0;
    bready = 1'b1; arvalid = 0; araddr = '0; arlen = '0; rready = 0;
    #3;
    chk_eq("rst_awready", awready, 1'b0);
    chk_eq("rst_arready", arready, 1'b0);
    chk_eq("rst_wready", wready, 1'b0);
    chk_eq("rst_bvalid", bvalid, 1'b0);
    chk_eq("rst_rvalid", rvalid, 1'b0);
    chk_eq("rst_rlast", rlast, 1'b0);
    chk_eq("rst_rdata", rdata, 64'd0);
    chk_eq("rst_perr", perr, 1'b0);
    @(negedge ap_clk);
    areset = 1'b0;

    // basic 4-beat write / readback at word 8
    for (int i = 0; i < 4; i++) begin wbuf[i] = i + 1; sbuf[i] = 8'hFF; ebuf[i] = i + 1; end
    wr_burst(64'h40, 3, 3);
    rd_burst(64'h40, 3, 0);

    // byte strobes on word 5
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
    wr_burst(64'h28, 0, 0);
    wbuf[0] = 64'h0; sbuf[0] = 8'h01;
    wr_burst(64'h28, 0, 0);
    ebuf[0] = 64'hFFFF_FFFF_FFFF_FF00;
    rd_burst(64'h28, 0, 0);

    // 8-beat read with back-pressure
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 64'h1000 + i; sbuf[i] = 8'hFF; ebuf[i] = 64'h1000 + i;
    end
    wr_burst(64'h0, 7, 7);
    rd_burst(64'h0, 7, 1);
    chk_eq("perr_clean", perr, 1'b0);

    // burst wrapping past the top of memory
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 64'h5000 + i; sbuf[i] = 8'hFF; ebuf[i] = 64'h5000 + i;
    end
    wr_burst(64'h70, 3, 3);
    rd_burst(64'h70, 3, 0);
    ebuf[0] = 64'h5002; ebuf[1] = 64'h5003;
    rd_burst(64'h0, 1, 0);

    // both address channels held high from reset: round-robin
    @(negedge ap_clk);
    areset = 1'b1;
    awaddr = 64'h0; awlen = 8'd0; araddr = 64'h0; arlen = 8'd0;
    wdata = 64'hA5; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    awvalid = 1'b1; arvalid = 1'b1; rready = 1'b1;
    @(negedge ap_clk);
    areset = 1'b0;
    order = 4'b0000; g = 0; t = 0;
    while (g < 4 && t < 60) begin
      #1;
      chk_eq("aw_ar_excl", awready & arready, 1'b0);
      if (awready) begin order[3-g] = 1'b1; g++; end
      else if (arready) begin order[3-g] = 1'b0; g++; end
      @(negedge ap_clk);
      t++;
    end
    awvalid = 1'b0; arvalid = 1'b0;
    chk_eq("rr_grants", g, 4);
    chk_eq("rr_order", order, 4'b1010);
    repeat (6) @(negedge ap_clk);
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;

    // early wlast sets the sticky error; beat count still ends the burst
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'h6000 + i; sbuf[i] = 8'hFF; end
    chk_eq("perr_pre", perr, 1'b0);
    wr_burst(64'h60, 3, 1);
    chk_eq("perr_set", perr, 1'b1);

    // reset in the middle of a stalled read
    @(negedge ap_clk);
    araddr = 64'h40; arlen = 8'd7; arvalid = 1'b1; rready = 1'b0;
    t = 0; #1;
    while (!arready && t < 50) begin @(negedge ap_clk); #1; t++; end
    @(negedge ap_clk);
    arvalid = 1'b0;
    t = 0; #1;
    while (!rvalid && t < 10) begin @(negedge ap_clk); #1; t++; end
    chk_eq("r_pending", rvalid, 1'b1);
    areset = 1'b1;
    #1;
    chk_eq("rst_mid_rvalid", rvalid, 1'b0);
    chk_eq("rst_mid_perr", perr, 1'b0);
    @(negedge ap_clk);
    areset = 1'b0;
    rready = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1 chk_eq("no_r_after_rst", rvalid, 1'b0);
    rready = 1'b0;
    for (int i = 0; i < 4; i++) ebuf[i] = i + 1;
    rd_burst(64'h40, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
